// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder, LSB first, one bit pair per clock.
// Optional two's-complement overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             carry_out
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cy;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;
    logic             w_s;
    logic             w_co;

    full_adder u_fa (
        .a         (r_a_sr[0]),
        .b         (r_b_sr[0]),
        .c_in      (r_cy),
        .sum       (w_s),
        .carry_out (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == LAST_BIT) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operand shifters, carry flop, bit counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_cy    <= 1'b0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_busy <= (w_next == S_SHIFT);
            r_done <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr <= op_a;
                        r_b_sr <= op_b;
                        r_cy   <= c_in;
                        r_cnt  <= '0;
                        r_acc  <= '0;
                    end
                end
                S_SHIFT: begin
                    r_acc  <= {w_s, r_acc[WIDTH-1:1]};
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_cy   <= w_co;
                    if (r_cnt == LAST_BIT) begin
                        // Counter parks at the last bit instead of wrapping.
                        r_sum   <= {w_s, r_acc[WIDTH-1:1]};
                        r_carry <= w_co;
                        r_ovf   <= r_cy ^ w_co;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign sum       = r_sum;
    assign carry_out = r_carry;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf       = r_ovf;
`else
    logic w_ovf_unused;
    assign w_ovf_unused = r_ovf;
`endif

endmodule

// 1-bit full adder cell driven by the serial controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic carry_out
);
    assign sum       = a ^ b ^ c_in;
    assign carry_out = (a & b) | (c_in & (a ^ b));
endmodule
